// File: rtl/interrupt_sched.sv
// interrupt_sched: fixed-priority interrupt take/return FSM plus programmable period counter; int_en1 one cycle after a qualified request.
// stallD/branch_stall_D hold off takes, stallE holds off counter config; INT_EDGE_DETECT_EN selects edge (vs level) capture of irq_ext.
module interrupt_sched #(
  parameter int NSRC      = 4,
  parameter int CNT_WIDTH = 16,
  parameter int ID_W      = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NSRC-2:0]      i_irq_ext,
  input  logic                 i_cnt_int_e,
  input  logic                 i_cnt_int_sel_e,
  input  logic                 i_cnt_int_disable_e,
  input  logic [CNT_WIDTH-1:0] i_cnt_data_e,
  input  logic                 i_stall_e,
  input  logic                 i_stall_d,
  input  logic                 i_branch_stall_d,
  input  logic                 i_rti,
  output logic                 o_int_en1,
  output logic [ID_W-1:0]      o_int_id,
  output logic                 o_in_service,
  output logic [NSRC-1:0]      o_pending
);

  typedef enum logic [1:0] {S_IDLE, S_TAKE, S_SERVICE, S_RETURN} state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_counter;
  logic                 r_cnt_en;
  logic [NSRC-1:0]      r_pending;
  logic                 r_int_en1;
  logic [ID_W-1:0]      r_int_id;
  logic                 r_in_service;

  logic                 w_cfg_dis;
  logic                 w_cfg_ld;
  logic                 w_cnt_run;
  logic                 w_cnt_fire;
  logic [NSRC-2:0]      w_ext_set;
  logic [NSRC-1:0]      w_set;
  logic [NSRC-1:0]      w_lowest_oh;
  logic [NSRC-1:0]      w_clr;
  logic [ID_W-1:0]      w_lowest_id;
  logic                 w_take;

  // Disable beats load; a config write pre-empts the running count for that cycle.
  assign w_cfg_dis  = i_cnt_int_e & ~i_stall_e & i_cnt_int_disable_e;
  assign w_cfg_ld   = i_cnt_int_e & ~i_stall_e & i_cnt_int_sel_e & ~i_cnt_int_disable_e;
  assign w_cnt_run  = r_cnt_en & (r_period != '0) & ~w_cfg_dis & ~w_cfg_ld;
  assign w_cnt_fire = w_cnt_run & (r_counter == CNT_WIDTH'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period  <= '0;
      r_counter <= '0;
      r_cnt_en  <= 1'b0;
    end else if (w_cfg_dis) begin
      r_cnt_en <= 1'b0;
    end else if (w_cfg_ld) begin
      r_period  <= i_cnt_data_e;
      r_counter <= i_cnt_data_e;
      r_cnt_en  <= 1'b1;
    end else if (w_cnt_run) begin
      r_counter <= w_cnt_fire ? r_period : r_counter - CNT_WIDTH'(1);
    end
  end

`ifdef INT_EDGE_DETECT_EN
  logic [NSRC-2:0] r_irq_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_irq_prev <= '0;
    else          r_irq_prev <= i_irq_ext;
  end

  assign w_ext_set = i_irq_ext & ~r_irq_prev;
`else
  assign w_ext_set = i_irq_ext;
`endif

  assign w_set = {w_ext_set, w_cnt_fire};

  always_comb begin
    w_lowest_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lowest_id = ID_W'(i);
    end
  end

  // Isolates the lowest set bit: the one cleared on a take.
  assign w_lowest_oh = r_pending & (~r_pending + NSRC'(1));
  assign w_take      = (r_state == S_IDLE) & (|r_pending) & ~i_stall_d & ~i_branch_stall_d;
  assign w_clr       = w_take ? w_lowest_oh : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_int_en1    <= 1'b0;
      r_int_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_int_en1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state   <= S_TAKE;
            r_int_en1 <= 1'b1;
            r_int_id  <= w_lowest_id;
          end
        end
        S_TAKE: begin
          r_state      <= S_SERVICE;
          r_in_service <= 1'b1;
        end
        S_SERVICE: begin
          if (i_rti & ~i_stall_d) r_state <= S_RETURN;
        end
        S_RETURN: begin
          r_state      <= S_IDLE;
          r_in_service <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_int_en1    = r_int_en1;
  assign o_int_id     = r_int_id;
  assign o_in_service = r_in_service;
  assign o_pending    = r_pending;

endmodule
